irq_request_latch: RTL and testbench

//   Upstream front end of the 8-input priority encoder. Synchronises raw request

---
 rtl/irq_request_latch.sv | 88 ++++++++
 tb/tb_irq_request_latch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_latch.sv
// irq_request_latch: synchronises raw request lines, turns rising edges into
// sticky pending bits cleared by indexed acknowledge, tracks per-line overflow
// and presents the masked pending vector to the downstream priority encoder.
module irq_request_latch #(
  parameter int              WIDTH    = 8,
  parameter int              IDX_W    = 3,
  parameter logic [WIDTH-1:0] MASK_RST = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_wdata,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] pend_vec,
  output logic             irq_any,
  output logic [WIDTH-1:0] ovf
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] mask;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] ack_hit;
  logic [WIDTH-1:0] ovf_set;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] ovf_next;

  // Two-flop synchroniser plus a delayed copy for edge detection. Resetting to
  // all-ones means a line already high at reset release never looks like a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Decode the acknowledge index into a one-hot clear vector; out-of-range
  // indices match no line and are therefore ignored.
  always_comb begin
    ack_hit = '0;
    if (ack_valid) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (ack_idx == IDX_W'(i)) ack_hit[i] = 1'b1;
      end
    end
  end

  // Next-state for pending and overflow: a new event beats a same-cycle ack,
  // and an event replacing an acked one is not an overflow. A fresh overflow
  // beats ovf_clr on its own bit.
  always_comb begin
    rise         = sync2 & ~prev;
    ovf_set      = rise & pending & ~ack_hit;
    pending_next = rise | (pending & ~ack_hit);
    ovf_next     = (ovf_clr ? '0 : ovf) | ovf_set;
  end

  // Pending, overflow and mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ovf     <= '0;
      mask    <= MASK_RST;
    end else begin
      pending <= pending_next;
      ovf     <= ovf_next;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Masking only hides pending bits from the encoder; it never clears them.
  always_comb begin
    pend_vec = pending & mask;
    irq_any  = |pend_vec;
  end

endmodule

// File: tb/tb_irq_request_latch.sv
// Self-checking bench for irq_request_latch: directed scenarios followed by a
// randomized run, all compared against an event-level reference model.
module tb_irq_request_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ack_valid;
  logic [2:0] ack_idx;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ovf_clr;
  logic [7:0] pend_vec;
  logic       irq_any;
  logic [7:0] ovf;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: history of req samples (index 0 = most recent edge),
  // plus pending / overflow / mask as plain bit sets.
  logic [7:0] hist[$];
  logic [7:0] m_pend;
  logic [7:0] m_ovf;
  logic [7:0] m_mask;

  irq_request_latch #(.WIDTH(8), .IDX_W(3), .MASK_RST(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack_valid (ack_valid),
    .ack_idx   (ack_idx),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .ovf_clr   (ovf_clr),
    .pend_vec  (pend_vec),
    .irq_any   (irq_any),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist = '{8'hFF, 8'hFF, 8'hFF};
    m_pend = 8'h00;
    m_ovf  = 8'h00;
    m_mask = 8'hFF;
  endtask

  // One clock edge of the reference model, applied to the inputs present at it.
  // A line produces an event when the sample two edges old is high and the
  // sample three edges old is low.
  task automatic model_edge();
    logic [7:0] newovf;
    bit ev, acked;
    newovf = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ev    = hist[1][i] && !hist[2][i];
      acked = ack_valid && (int'(ack_idx) == i);
      if (ev) begin
        if (m_pend[i] && !acked) newovf[i] = 1'b1;
        m_pend[i] = 1'b1;
      end else if (acked) begin
        m_pend[i] = 1'b0;
      end
    end
    m_ovf = (ovf_clr ? 8'h00 : m_ovf) | newovf;
    if (mask_we) m_mask = mask_wdata;
    hist.push_front(req);
    void'(hist.pop_back());
  endtask

  // Advance one cycle, compare all outputs, then drop the single-cycle pulses.
  task automatic cyc();
    logic [7:0] exp_vec;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_vec = m_pend & m_mask;
    check("pend_vec", pend_vec, exp_vec);
    check("irq_any", {7'b0, irq_any}, {7'b0, |exp_vec});
    check("ovf", ovf, m_ovf);
    ack_valid = 1'b0;
    mask_we   = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    rst       = 1'b1;
    ack_valid = 1'b0;
    mask_we   = 1'b0;
    ovf_clr   = 1'b0;
    #1;
    model_reset();
    check("rst_pend_vec", pend_vec, 8'h00);
    check("rst_irq_any", {7'b0, irq_any}, 8'h00);
    check("rst_ovf", ovf, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ack(input logic [2:0] idx);
    ack_valid = 1'b1;
    ack_idx   = idx;
  endtask

  initial begin
    rst = 1'b0; req = 8'h00; ack_valid = 1'b0; ack_idx = 3'd0;
    mask_we = 1'b0; mask_wdata = 8'h00; ovf_clr = 1'b0;
    model_reset();

    // 1: latency of a rise after the synchroniser has seen the lines low
    @(negedge clk);
    apply_reset();
    cycles(4);
    req = 8'h24;
    cyc(); check("t1_edge_k", pend_vec, 8'h00);
    cyc(); check("t1_edge_k1", pend_vec, 8'h00);
    cyc(); check("t1_edge_k2", pend_vec, 8'h24);
    check("t1_irq", {7'b0, irq_any}, 8'h01);

    // 3: indexed acknowledge, repeat ack is a no-op
    ack(3'd5); cyc(); check("t3_ack5", pend_vec, 8'h04);
    ack(3'd5); cyc(); check("t3_ack5_again", pend_vec, 8'h04);
    ack(3'd2); cyc(); check("t3_ack2", pend_vec, 8'h00);
    check("t3_irq", {7'b0, irq_any}, 8'h00);

    // 4: overflow, overflow clear, ack coinciding with a new event
    req = 8'h00; cycles(3);
    req = 8'h08; cycles(3);
    check("t4_pend", pend_vec, 8'h08);
    req = 8'h00; cycles(3);
    req = 8'h08; cycles(3);
    check("t4_ovf", ovf, 8'h08);
    ovf_clr = 1'b1; cyc(); check("t4_ovf_clr", ovf, 8'h00);
    req = 8'h00; cycles(3);
    req = 8'h08; cycles(2);
    ack(3'd3); cyc();
    check("t4_ack_coincide_pend", pend_vec, 8'h08);
    check("t4_ack_coincide_ovf", ovf, 8'h00);

    // 5: masking hides but keeps pending
    ack(3'd3); cyc();
    mask_we = 1'b1; mask_wdata = 8'h00; cyc();
    req = 8'h00; cycles(3);
    req = 8'h80; cycles(3);
    check("t5_masked", pend_vec, 8'h00);
    check("t5_masked_irq", {7'b0, irq_any}, 8'h00);
    mask_we = 1'b1; mask_wdata = 8'hFF; cyc();
    check("t5_unmasked", pend_vec, 8'h80);

    // 6: async reset mid-operation, mask returns to all-enabled
    req = 8'h81; cycles(3);
    req = 8'h80; cycles(3);
    req = 8'h81; cycles(3);
    check("t6_ovf", ovf, 8'h01);
    mask_we = 1'b1; mask_wdata = 8'h0F; cyc();
    check("t6_mask0f", pend_vec, 8'h01);
    apply_reset();
    req = 8'h00; cycles(3);
    req = 8'h80; cycles(3);
    check("t6_mask_after_reset", pend_vec, 8'h80);

    // 2: lines held high through reset release make no events
    req = 8'hFF;
    apply_reset();
    cycles(20);
    check("t2_held_high", pend_vec, 8'h00);
    check("t2_held_high_irq", {7'b0, irq_any}, 8'h00);

    // Randomized run: lines toggle occasionally so edges are spaced out
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ 8'($urandom);
      if ($urandom_range(0, 2) == 0) ack(3'($urandom));
      if ($urandom_range(0, 15) == 0) begin
        mask_we = 1'b1;
        mask_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 20) == 0) ovf_clr = 1'b1;
      if ($urandom_range(0, 150) == 0) apply_reset();
      else cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
